// File: rtl/div_pipe_sr.sv
// rtl/div_pipe_sr.sv - fully pipelined restoring divider with valid/ready, tag, dz/ovf flags.
// Optional macro DIV_PIPE_SKID_EN adds a 2-entry output skid buffer with a registered s_ready_o.
module div_pipe_sr #(
  parameter int DWA    = 32,
  parameter int DWB    = 32,
  parameter int N_PIPE = 8,
  parameter int TW     = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  input  logic           s_signed_i,
  input  logic [DWA-1:0] s_a_i,
  input  logic [DWB-1:0] s_b_i,
  input  logic [TW-1:0]  s_tag_i,
  output logic           m_valid_o,
  input  logic           m_ready_i,
  output logic [DWA-1:0] m_quot_o,
  output logic [DWB-1:0] m_rem_o,
  output logic [TW-1:0]  m_tag_o,
  output logic           m_dz_o,
  output logic           m_ovf_o
);

  localparam int BPS = DWA / N_PIPE;
  localparam int W   = DWA + DWB;

  if ((DWA % N_PIPE) != 0) begin : g_bad_cfg
    $error("div_pipe_sr: DWA must be a multiple of N_PIPE");
  end

  logic [N_PIPE:0] vld_q, vld_d, sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [DWA-1:0]  rem_q [0:N_PIPE];
  logic [DWA-1:0]  rem_d [0:N_PIPE];
  logic [DWA-1:0]  quo_q [0:N_PIPE];
  logic [DWA-1:0]  quo_d [0:N_PIPE];
  logic [DWB-1:0]  bmg_q [0:N_PIPE];
  logic [DWB-1:0]  bmg_d [0:N_PIPE];
  logic [TW-1:0]   tag_q [0:N_PIPE];
  logic [TW-1:0]   tag_d [0:N_PIPE];
  logic            adv;
  logic            a_neg, b_neg;
  logic [DWA-1:0]  quot_c;
  logic [DWB-1:0]  rem_mag, rem_c;

  assign a_neg = s_signed_i & s_a_i[DWA-1];
  assign b_neg = s_signed_i & s_b_i[DWB-1];

  always_comb begin
    logic [W-1:0]   r;
    logic [W-1:0]   t;
    logic [DWA-1:0] q;
    r = '0;
    t = '0;
    q = '0;
    vld_d = {vld_q[N_PIPE-1:0], s_valid_i};
    sq_d  = {sq_q[N_PIPE-1:0], a_neg ^ b_neg};
    sr_d  = {sr_q[N_PIPE-1:0], a_neg};
    dz_d  = {dz_q[N_PIPE-1:0], s_b_i == '0};
    ovf_d = {ovf_q[N_PIPE-1:0],
             s_signed_i & (s_a_i == {1'b1, {(DWA-1){1'b0}}}) & (&s_b_i)};
    rem_d[0] = a_neg ? DWA'(0) - s_a_i : s_a_i;
    quo_d[0] = '0;
    bmg_d[0] = b_neg ? DWB'(0) - s_b_i : s_b_i;
    tag_d[0] = s_tag_i;
    for (int i = 1; i <= N_PIPE; i++) begin
      r = {{DWB{1'b0}}, rem_q[i-1]};
      q = quo_q[i-1];
      for (int s = 0; s < BPS; s++) begin
        t = {{DWA{1'b0}}, bmg_q[i-1]} << (DWA - 1 - (i-1)*BPS - s);
        if (r >= t) begin
          r = r - t;
          q = q | (DWA'(1) << (DWA - 1 - (i-1)*BPS - s));
        end
      end
      rem_d[i] = r[DWA-1:0];
      quo_d[i] = q;
      bmg_d[i] = bmg_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      sq_q  <= '0;
      sr_q  <= '0;
      dz_q  <= '0;
      ovf_q <= '0;
      for (int i = 0; i <= N_PIPE; i++) begin
        rem_q[i] <= '0;
        quo_q[i] <= '0;
        bmg_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      sq_q  <= sq_d;
      sr_q  <= sr_d;
      dz_q  <= dz_d;
      ovf_q <= ovf_d;
      for (int i = 0; i <= N_PIPE; i++) begin
        rem_q[i] <= rem_d[i];
        quo_q[i] <= quo_d[i];
        bmg_q[i] <= bmg_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // With |B| = 0 every step subtracts zero, so the remainder is |A| and the
  // sign fix-up turns it back into raw A; overflow also falls out naturally.
  assign rem_mag = rem_q[N_PIPE][DWB-1:0];
  assign quot_c  = dz_q[N_PIPE] ? '1 : (sq_q[N_PIPE] ? DWA'(0) - quo_q[N_PIPE] : quo_q[N_PIPE]);
  assign rem_c   = sr_q[N_PIPE] ? DWB'(0) - rem_mag : rem_mag;

`ifdef DIV_PIPE_SKID_EN
  localparam int OW = DWA + DWB + TW + 2;

  logic [OW-1:0] res_w, out_w;
  logic [OW-1:0] skid_q [0:1];
  logic          wr_q, rd_q, empty, push, pop;
  logic [1:0]    cnt_q;

  assign res_w     = {quot_c, rem_c, tag_q[N_PIPE], dz_q[N_PIPE], ovf_q[N_PIPE]};
  assign empty     = cnt_q == 2'd0;
  assign adv       = cnt_q != 2'd2;
  assign s_ready_o = adv;
  assign pop       = ~empty & m_ready_i;
  // Last stage bypasses the buffer only when it is empty and downstream takes it.
  assign push      = adv & vld_q[N_PIPE] & ~(empty & m_ready_i);
  assign m_valid_o = empty ? vld_q[N_PIPE] : 1'b1;
  assign out_w     = empty ? res_w : skid_q[rd_q];
  assign {m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o} = out_w;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      if (push) begin
        skid_q[wr_q] <= res_w;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  assign m_valid_o = vld_q[N_PIPE];
  assign adv       = ~(m_valid_o & ~m_ready_i);
  assign s_ready_o = adv;
  assign m_quot_o  = quot_c;
  assign m_rem_o   = rem_c;
  assign m_tag_o   = tag_q[N_PIPE];
  assign m_dz_o    = dz_q[N_PIPE];
  assign m_ovf_o   = ovf_q[N_PIPE];
`endif

endmodule

// File: tb/tb_div_pipe_sr.sv
// tb/tb_div_pipe_sr.sv - scoreboard bench for div_pipe_sr (main 32/32/8 plus 16/8 sweeps).
module tb_div_pipe_sr;
  localparam int NP = 8;

  typedef struct {
    logic [31:0] quot;
    logic [31:0] rem;
    logic [3:0]  tag;
    logic        dz;
    logic        ovf;
    bit          chk_lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_valid_i = 1'b0, s_signed_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_a_i = '0, s_b_i = '0;
  logic [3:0]  s_tag_i = '0;
  logic        m_valid_o, m_dz_o, m_ovf_o;
  logic        m_ready_i = 1'b1;
  logic [31:0] m_quot_o, m_rem_o;
  logic [3:0]  m_tag_o;

  logic        sw_valid = 1'b0, sw_sgn = 1'b0, sw_rdy = 1'b1;
  logic [15:0] sw_a = '0;
  logic [7:0]  sw_b = '0;
  logic [3:0]  sw_tag = '0;
  logic        sw_srdy [3];
  logic        sw_v [3];
  logic        sw_dz [3];
  logic        sw_ovf [3];
  logic [15:0] sw_q [3];
  logic [7:0]  sw_r [3];
  logic [3:0]  sw_t [3];
  int          swn [3] = '{1, 4, 16};

  exp_t        sb [$];
  int          tests = 0, fails = 0, cyc = 0, stall_waits = 0;
  bit          rand_rdy = 1'b0;
  bit          prev_stall = 1'b0;
  logic [70:0] held;

  div_pipe_sr #(.DWA(32), .DWB(32), .N_PIPE(NP), .TW(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_signed_i(s_signed_i), .s_a_i(s_a_i), .s_b_i(s_b_i), .s_tag_i(s_tag_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_quot_o(m_quot_o), .m_rem_o(m_rem_o),
    .m_tag_o(m_tag_o), .m_dz_o(m_dz_o), .m_ovf_o(m_ovf_o));

  div_pipe_sr #(.DWA(16), .DWB(8), .N_PIPE(1), .TW(4)) sw0 (
    .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(sw_valid), .s_ready_o(sw_srdy[0]),
    .s_signed_i(sw_sgn), .s_a_i(sw_a), .s_b_i(sw_b), .s_tag_i(sw_tag),
    .m_valid_o(sw_v[0]), .m_ready_i(sw_rdy), .m_quot_o(sw_q[0]), .m_rem_o(sw_r[0]),
    .m_tag_o(sw_t[0]), .m_dz_o(sw_dz[0]), .m_ovf_o(sw_ovf[0]));

  div_pipe_sr #(.DWA(16), .DWB(8), .N_PIPE(4), .TW(4)) sw1 (
    .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(sw_valid), .s_ready_o(sw_srdy[1]),
    .s_signed_i(sw_sgn), .s_a_i(sw_a), .s_b_i(sw_b), .s_tag_i(sw_tag),
    .m_valid_o(sw_v[1]), .m_ready_i(sw_rdy), .m_quot_o(sw_q[1]), .m_rem_o(sw_r[1]),
    .m_tag_o(sw_t[1]), .m_dz_o(sw_dz[1]), .m_ovf_o(sw_ovf[1]));

  div_pipe_sr #(.DWA(16), .DWB(8), .N_PIPE(16), .TW(4)) sw2 (
    .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(sw_valid), .s_ready_o(sw_srdy[2]),
    .s_signed_i(sw_sgn), .s_a_i(sw_a), .s_b_i(sw_b), .s_tag_i(sw_tag),
    .m_valid_o(sw_v[2]), .m_ready_i(sw_rdy), .m_quot_o(sw_q[2]), .m_rem_o(sw_r[2]),
    .m_tag_o(sw_t[2]), .m_dz_o(sw_dz[2]), .m_ovf_o(sw_ovf[2]));

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    m_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic [3:0] tg,
                              input logic dz, input logic ovf);
    exp_t e;
    e.quot = q; e.rem = r; e.tag = tg; e.dz = dz; e.ovf = ovf; e.chk_lat = 1'b1; e.acc = 0;
    return e;
  endfunction

  // Reference: plain 64-bit integer division, which truncates toward zero.
  function automatic exp_t model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] tg);
    exp_t   e;
    longint x, y, q, r;
    e.tag = tg; e.dz = 1'b0; e.ovf = 1'b0; e.chk_lat = 1'b0; e.acc = 0;
    x = sg ? longint'($signed(a)) : longint'(a);
    y = sg ? longint'($signed(b)) : longint'(b);
    if (y == 0) begin
      e.dz = 1'b1; e.quot = 32'hFFFF_FFFF; e.rem = a;
    end else if (sg && x == -64'sd2147483648 && y == -1) begin
      e.ovf = 1'b1; e.quot = 32'h8000_0000; e.rem = 32'h0;
    end else begin
      q = x / y;
      r = x % y;
      e.quot = q[31:0];
      e.rem  = r[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if ({m_valid_o, m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o} !== held) begin
          fails++;
          $display("FAIL hold_stable: got %h required %h",
                   {m_valid_o, m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o}, held);
        end
      end
      if (m_valid_o && m_ready_i) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got quot=%h rem=%h tag=%h, required no output",
                   m_quot_o, m_rem_o, m_tag_o);
        end else begin
          e = sb.pop_front();
          if (m_quot_o !== e.quot || m_rem_o !== e.rem || m_tag_o !== e.tag ||
              m_dz_o !== e.dz || m_ovf_o !== e.ovf ||
              (e.chk_lat && cyc != e.acc + 1 + NP)) begin
            fails++;
            $display("FAIL result: got q=%h r=%h t=%h dz=%b ovf=%b cyc=%0d required q=%h r=%h t=%h dz=%b ovf=%b cyc=%0d",
                     m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o, cyc,
                     e.quot, e.rem, e.tag, e.dz, e.ovf, e.chk_lat ? e.acc + 1 + NP : cyc);
          end
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      held = {m_valid_o, m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o};
    end
  end

  task automatic send(input bit sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tg, input exp_t e);
    int w;
    w = 0;
    s_valid_i = 1'b1; s_signed_i = sg; s_a_i = a; s_b_i = b; s_tag_i = tg;
    forever begin
      @(negedge clk);
      if (s_ready_o) begin
        e.acc = cyc;
        sb.push_back(e);
        break;
      end
      w++;
      stall_waits++;
      if (w > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: got no s_ready_o in %0d cycles, required ready", w);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_valid_i = 1'b0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic rand_op(input bit chk);
    bit          sg;
    logic [31:0] a, b;
    logic [3:0]  tg;
    exp_t        e;
    sg = 1'($urandom_range(0, 1));
    tg = 4'($urandom);
    case ($urandom_range(0, 4))
      0:       a = 32'h8000_0000;
      1:       a = 32'($urandom_range(0, 255));
      default: a = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0:       b = 32'h0;
      1:       b = 32'hFFFF_FFFF;
      2:       b = 32'($urandom_range(1, 15));
      default: b = $urandom;
    endcase
    e = model(sg, a, b, tg);
    e.chk_lat = chk;
    send(sg, a, b, tg, e);
  endtask

  initial begin
    int waits0, vis, acc;
    int seen [3];

    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({m_valid_o, m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o} !== 71'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {m_valid_o, m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o});
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    tests++;
    if (s_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", s_ready_o);
    end
    @(posedge clk); #1;

    send(0, 32'd100, 32'd7, 4'd3, mk(32'd14, 32'd2, 4'd3, 0, 0));
    send(1, -32'sd7, 32'd2, 4'd1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'd1, 0, 0));
    send(1, 32'd7, -32'sd2, 4'd2, mk(32'hFFFF_FFFD, 32'd1, 4'd2, 0, 0));
    send(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, mk(32'h8000_0000, 32'd0, 4'd4, 0, 1));
    send(0, 32'h1234, 32'd0, 4'd5, mk(32'hFFFF_FFFF, 32'h1234, 4'd5, 1, 0));
    send(1, 32'h1234, 32'd0, 4'd6, mk(32'hFFFF_FFFF, 32'h1234, 4'd6, 1, 0));
    send(0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, mk(32'd0, 32'h8000_0000, 4'd7, 0, 0));
    send(1, 32'h8000_0000, 32'd0, 4'd8, mk(32'hFFFF_FFFF, 32'h8000_0000, 4'd8, 1, 0));
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) rand_op(1'b0);
    rand_rdy = 1'b0;
    drain();

    waits0 = stall_waits;
    for (int i = 0; i < 16; i++) rand_op(1'b1);
    drain();
    tests++;
    if (stall_waits != waits0) begin
      fails++;
      $display("FAIL full_rate: got %0d refused cycles, required 0", stall_waits - waits0);
    end

    for (int i = 0; i < 5; i++) rand_op(1'b0);
    s_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    sb.delete();
    @(negedge clk);
    tests++;
    if (s_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b required 1", s_ready_o);
    end
    vis = 0;
    repeat (NP + 4) begin
      @(negedge clk);
      if (m_valid_o) vis++;
    end
    tests++;
    if (vis != 0) begin
      fails++;
      $display("FAIL flush_on_reset: got %0d valid cycles, required 0", vis);
    end
    @(posedge clk); #1;
    send(0, 32'd1000, 32'd10, 4'd9, mk(32'd100, 32'd0, 4'd9, 0, 0));
    drain();

    sw_a = 16'hFFFF; sw_b = 8'hFF; sw_tag = 4'd5; sw_sgn = 1'b0; sw_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    tests++;
    if (!(sw_srdy[0] && sw_srdy[1] && sw_srdy[2])) begin
      fails++;
      $display("FAIL sweep_ready: got %b%b%b required 111", sw_srdy[0], sw_srdy[1], sw_srdy[2]);
    end
    @(posedge clk); #1;
    sw_valid = 1'b0;
    seen = '{0, 0, 0};
    repeat (24) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (sw_v[j]) begin
          seen[j]++;
          tests++;
          if (cyc != acc + 1 + swn[j] || sw_q[j] !== 16'h0101 || sw_r[j] !== 8'h00 ||
              sw_t[j] !== 4'd5 || sw_dz[j] !== 1'b0 || sw_ovf[j] !== 1'b0) begin
            fails++;
            $display("FAIL sweep_n%0d: got q=%h r=%h cyc=%0d required q=0101 r=00 cyc=%0d",
                     swn[j], sw_q[j], sw_r[j], cyc, acc + 1 + swn[j]);
          end
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      tests++;
      if (seen[j] != 1) begin
        fails++;
        $display("FAIL sweep_count_n%0d: got %0d results required 1", swn[j], seen[j]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_pipe_sr.md
Name: div_pipe_sr

Overview:
- Fully pipelined restoring integer divider; next generation of the team's combinational and iterative dividers.
- Adds independent dividend/divisor widths, a per-operation signed/unsigned mode, valid/ready handshakes with back-pressure, and a tag passthrough.
- Adds divide-by-zero and signed-overflow flags.
- Sits between the ALU issue logic and the writeback arbiter; accepts one operation per cycle.

Parameters:
- DWA, 32, dividend and quotient width (bits); DWA >= 2.
- DWB, 32, divisor and remainder width (bits); 2 <= DWB <= DWA.
- N_PIPE, 8, number of register stages; DWA % N_PIPE must be 0, otherwise elaboration fails ($error). Each stage resolves BPS = DWA/N_PIPE quotient bits.
- TW, 4, tag width carried alongside each operation.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- s_valid_i  in  1  input operation valid.
- s_ready_o  out  1  divider can accept an operation this cycle.
- s_signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- s_a_i  in  DWA  dividend.
- s_b_i  in  DWB  divisor.
- s_tag_i  in  TW  user tag.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  downstream accepts the result.
- m_quot_o  out  DWA  quotient.
- m_rem_o  out  DWB  remainder.
- m_tag_o  out  TW  tag of the result.
- m_dz_o  out  1  divide by zero.
- m_ovf_o  out  1  signed overflow (A = -2^(DWA-1), B = -1).

Behaviour:
- Reset (rst_ni = 0 at a clock edge):
  - All stage valid bits cleared.
  - m_valid_o, m_quot_o, m_rem_o, m_tag_o, m_dz_o, m_ovf_o all reset to 0.
  - s_ready_o reads 1 on the first cycle after release.
  - Operations in flight during reset are discarded; there is no partial output.
- Handshake:
  - Transfer occurs when valid & ready.
  - m_* outputs are held stable while m_valid_o = 1 and m_ready_i = 0.
- Stall rule:
  - stall = m_valid_o & ~m_ready_i.
  - s_ready_o = ~stall, a combinational path from m_ready_i.
  - On stall, every stage register holds its value, bubbles included; no bubble collapsing.
- Latency and throughput:
  - An operation accepted at edge k appears on m_* after edge k+N_PIPE, given no stalls.
  - Throughput is 1 operation per cycle.
  - Each stall cycle adds exactly 1 cycle to the latency of every operation in flight.
- Stage 0, registered at accept:
  - Operands are converted to magnitudes |A| (DWA bits) and |B| (DWB bits).
  - Stored with the operands: sign_q = signed & (A[msb] ^ B[msb]), sign_r = signed & A[msb], dz = (B == 0), ovf = signed & (A == 100..0) & (B == 11..1), and the tag.
- Stage i (1..N_PIPE):
  - Performs BPS restoring steps for quotient bits DWA-1-(i-1)*BPS down to DWA-BPS-(i-1)*BPS.
  - Each step compares the partial remainder against |B| << bit in a DWA+DWB-bit space and subtracts when greater or equal.
  - Quotient bits are carried per stage in registers, never shared combinationally across stages.
- Final correction, combinational off the last stage:
  - Q = sign_q ? -|Q| : |Q|.
  - R = sign_r ? -|R| : |R|.
  - Division truncates toward zero; the remainder takes the sign of the dividend.
- Special cases:
  - dz = 1: quotient = all ones; remainder = A[DWB-1:0] (raw input); ovf = 0.
  - ovf = 1: quotient = -2^(DWA-1); remainder = 0; dz = 0.
  - Unsigned mode never asserts ovf.
- Simultaneous accept and drain in the same cycle is legal and required to sustain full rate.
- Changing s_signed_i per operation is legal; mode travels with the operation.

Optional Feature:
- Macro: DIV_PIPE_SKID_EN.
- Defined:
  - A 2-entry skid buffer sits on the output.
  - s_ready_o becomes a registered signal, with no combinational path from m_ready_i.
  - Stage registers advance whenever the skid buffer is not full.
  - Latency is unchanged when m_ready_i stays high; the skid buffer absorbs up to 2 results during a stall.
- Undefined: global stall exactly as described in Behaviour.

Test Plan:
- Unsigned, DWA = DWB = 32, N_PIPE = 8: A = 100, B = 7, tag = 3 -> after 8 cycles, quot = 14, rem = 2, tag = 3, dz = 0, ovf = 0.
- Signed: (-7)/2 -> quot = -3, rem = -1. 7/(-2) -> quot = -3, rem = 1. A = 0x80000000 / -1 -> quot = 0x80000000, rem = 0, ovf = 1.
- Divide by zero: A = 0x1234, B = 0 in both modes -> quot = 0xFFFFFFFF, rem = 0x1234, dz = 1.
- Back-to-back stream of 64 random operations with m_ready_i toggling at random:
  - Results in order, matching the reference model.
  - No drops or duplicates.
  - Outputs stable while stalled.
  - 100% throughput when m_ready_i = 1.
- rst_ni asserted for 1 cycle with 5 operations in flight -> no m_valid_o afterwards; a new operation completes after exactly N_PIPE cycles.
- Parameter sweeps, unsigned: DWA = 16, DWB = 8, N_PIPE in {1, 4, 16}, A = 0xFFFF, B = 0xFF -> quot = 0x0101, rem = 0, latency = N_PIPE.
